// File: rtl/fifo_share_ctrl.sv
// fifo_share_ctrl
//
// Shares one DEEP-entry shift-register FIFO between two write requesters (A, B)
// and a single downstream consumer. Writes are arbitrated round-robin and gated on
// free space; reads are gated on occupancy. The FIFO's one-cycle registered read
// latency is absorbed into a registered valid/ready output stage.
//
// Ports
//   CLK, RSTn            clock (rising edge), asynchronous active-low reset
//   A_Req_i/A_Data_i     requester A word, held until A_Ack_o
//   A_Ack_o              combinational, high in the cycle A's word is written
//   B_Req_i/B_Data_i     requester B word, held until B_Ack_o
//   B_Ack_o              combinational, high in the cycle B's word is written
//   Write_Req_o          FIFO write strobe (combinational)
//   FIFO_Write_Data_o    granted requester's word, 0 with no grant
//   Read_Req_o           FIFO read strobe (combinational from state)
//   FIFO_Read_Data_i     FIFO head word, valid the cycle after Read_Req_o
//   Left_Sig_i           FIFO free slots (DEEP = empty, 0 = full)
//   Out_Valid_o          registered, Out_Data_o holds a word
//   Out_Data_o           registered output word
//   Out_Ready_i          consumer accepts when Out_Valid_o && Out_Ready_i

module fifo_share_ctrl #(
    parameter int unsigned DEEP = 4,
    parameter int unsigned DW   = 16,
    localparam int unsigned LW  = $clog2(DEEP + 1)
) (
    input  logic          CLK,
    input  logic          RSTn,
    input  logic          A_Req_i,
    input  logic [DW-1:0] A_Data_i,
    output logic          A_Ack_o,
    input  logic          B_Req_i,
    input  logic [DW-1:0] B_Data_i,
    output logic          B_Ack_o,
    output logic          Write_Req_o,
    output logic [DW-1:0] FIFO_Write_Data_o,
    output logic          Read_Req_o,
    input  logic [DW-1:0] FIFO_Read_Data_i,
    input  logic [LW-1:0] Left_Sig_i,
    output logic          Out_Valid_o,
    output logic [DW-1:0] Out_Data_o,
    input  logic          Out_Ready_i
);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StHold
    } state_e;

    state_e        state_q, state_d;
    logic          pri_q, pri_d;
    logic          out_valid_q, out_valid_d;
    logic [DW-1:0] out_data_q, out_data_d;

    logic can_wr, can_rd;
    logic gnt_a, gnt_b;
    logic rd_req;

    assign can_wr = (Left_Sig_i != '0);
    assign can_rd = (Left_Sig_i != LW'(DEEP));

    // Grants are masked during reset so no requester sees an Ack while RSTn is low.
    // pri_q picks the winner only when both requesters are active.
    assign gnt_a = RSTn && can_wr && A_Req_i && (!B_Req_i || !pri_q);
    assign gnt_b = RSTn && can_wr && B_Req_i && (!A_Req_i || pri_q);

    assign A_Ack_o           = gnt_a;
    assign B_Ack_o           = gnt_b;
    assign Write_Req_o       = gnt_a || gnt_b;
    assign FIFO_Write_Data_o = gnt_a ? A_Data_i : (gnt_b ? B_Data_i : '0);

    // After a grant, priority passes to the requester that lost (or was idle).
    always_comb begin
        pri_d = pri_q;
        if (gnt_a) begin
            pri_d = 1'b1;
        end else if (gnt_b) begin
            pri_d = 1'b0;
        end
    end

    // Read FSM: Idle issues a read, Wait captures the FIFO's registered head word,
    // Hold presents it until the consumer takes it (and may chain the next read).
    always_comb begin
        state_d     = state_q;
        rd_req      = 1'b0;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        unique case (state_q)
            StIdle: begin
                if (can_rd) begin
                    rd_req  = 1'b1;
                    state_d = StWait;
                end
            end
            StWait: begin
                out_data_d  = FIFO_Read_Data_i;
                out_valid_d = 1'b1;
                state_d     = StHold;
            end
            StHold: begin
                if (Out_Ready_i) begin
                    out_valid_d = 1'b0;
                    if (can_rd) begin
                        rd_req  = 1'b1;
                        state_d = StWait;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign Read_Req_o  = RSTn && rd_req;
    assign Out_Valid_o = out_valid_q;
    assign Out_Data_o  = out_data_q;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q     <= StIdle;
            pri_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            pri_q       <= pri_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

endmodule

// File: tb/tb_fifo_share_ctrl.sv
// Bench for fifo_share_ctrl. Contains a behavioural model of the 4-deep FIFO the
// controller sits beside, a table of arbiter/read-strobe vectors (Left_Sig forced),
// hand-written corner sequences and a randomized run against a scoreboard.

module tb_fifo_share_ctrl;

    localparam int unsigned DEEP = 4;

    logic        CLK = 1'b0;
    logic        RSTn = 1'b0;
    logic        A_Req = 1'b0, B_Req = 1'b0;
    logic [15:0] A_Data = '0, B_Data = '0;
    logic        A_Ack, B_Ack;
    logic        Write_Req, Read_Req;
    logic [15:0] FIFO_Write_Data;
    logic [15:0] FIFO_Read_Data;
    logic [2:0]  Left_Sig;
    logic        Out_Valid;
    logic [15:0] Out_Data;
    logic        Out_Ready = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    fifo_share_ctrl #(.DEEP(DEEP), .DW(16)) dut (
        .CLK               (CLK),
        .RSTn              (RSTn),
        .A_Req_i           (A_Req),
        .A_Data_i          (A_Data),
        .A_Ack_o           (A_Ack),
        .B_Req_i           (B_Req),
        .B_Data_i          (B_Data),
        .B_Ack_o           (B_Ack),
        .Write_Req_o       (Write_Req),
        .FIFO_Write_Data_o (FIFO_Write_Data),
        .Read_Req_o        (Read_Req),
        .FIFO_Read_Data_i  (FIFO_Read_Data),
        .Left_Sig_i        (Left_Sig),
        .Out_Valid_o       (Out_Valid),
        .Out_Data_o        (Out_Data),
        .Out_Ready_i       (Out_Ready)
    );

    // ---------------- FIFO model ----------------
    logic        tbl_mode = 1'b0;
    logic [2:0]  tbl_left = 3'd4;
    logic [15:0] fq[$];
    logic [2:0]  left_q;
    logic [15:0] fifo_rd_q;

    assign Left_Sig       = tbl_mode ? tbl_left : left_q;
    assign FIFO_Read_Data = fifo_rd_q;

    always @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            fq.delete();
            left_q    <= 3'(DEEP);
            fifo_rd_q <= '0;
        end else if (!tbl_mode) begin
            if (Read_Req) begin
                checks++;
                if (fq.size() == 0) begin
                    errors++;
                    $display("FAIL fifo_underrun: Read_Req=1 with FIFO empty, required no read");
                end else begin
                    fifo_rd_q <= fq.pop_front();
                end
            end
            if (Write_Req) begin
                checks++;
                if (fq.size() >= DEEP) begin
                    errors++;
                    $display("FAIL fifo_overflow: Write_Req=1 with FIFO full, required no write");
                end else begin
                    fq.push_back(FIFO_Write_Data);
                end
            end
            left_q <= 3'(DEEP - fq.size());
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Leaves the bench just after a rising edge with reset released.
    task automatic do_reset();
        @(posedge CLK); #1;
        RSTn = 1'b0;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        RSTn = 1'b1;
    endtask

    // Each step: inputs set just after posedge, outputs sampled on negedge.
    task automatic next_cycle();
        @(posedge CLK); #1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        a, b;
        logic [2:0]  left;
        logic        ack_a, ack_b, rd;
        logic [15:0] wdata;
    } vec_t;

    vec_t tbl[11];

    // ---------------- random-phase reference state ----------------
    logic [15:0] sb[$];
    logic        pri_m;
    logic        last_ack_a, last_ack_b;
    logic [1:0]  rd_hist;
    logic        was_stall;
    logic [15:0] stall_data;

    task automatic rand_step(input bit active);
        logic ea, eb;
        logic [15:0] ew;
        if (active) begin
            if (!A_Req || last_ack_a) begin
                A_Req  = 1'($urandom_range(0, 1));
                A_Data = 16'($urandom);
            end
            if (!B_Req || last_ack_b) begin
                B_Req  = 1'($urandom_range(0, 1));
                B_Data = 16'($urandom);
            end
            Out_Ready = ($urandom_range(0, 3) != 0);
        end else begin
            A_Req     = 1'b0;
            B_Req     = 1'b0;
            Out_Ready = 1'b1;
        end
        @(negedge CLK);
        // Arbiter rule: with space, a lone requester wins; on contention the
        // pointer decides and then points at the loser.
        ea = 1'b0;
        eb = 1'b0;
        if (Left_Sig != 0) begin
            if (A_Req && B_Req) begin
                if (pri_m) eb = 1'b1;
                else ea = 1'b1;
            end else begin
                ea = A_Req;
                eb = B_Req;
            end
        end
        ew = ea ? A_Data : (eb ? B_Data : 16'h0);
        chk("rnd_ack_a", 32'(A_Ack), 32'(ea));
        chk("rnd_ack_b", 32'(B_Ack), 32'(eb));
        chk("rnd_wdata", 32'(FIFO_Write_Data), 32'(ew));
        if (ea) begin
            sb.push_back(A_Data);
            pri_m = 1'b1;
        end else if (eb) begin
            sb.push_back(B_Data);
            pri_m = 1'b0;
        end
        if (rd_hist[1]) chk("rnd_rd_latency", 32'(Out_Valid), 32'd1);
        rd_hist = {rd_hist[0], Read_Req};
        if (was_stall) chk("rnd_stall_hold", 32'({Out_Valid, Out_Data}), 32'({1'b1, stall_data}));
        was_stall  = Out_Valid && !Out_Ready;
        stall_data = Out_Data;
        if (Out_Valid && Out_Ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rnd_sb_extra: got word 0x%0h, expected none", Out_Data);
            end else begin
                chk("rnd_sb_order", 32'(Out_Data), 32'(sb.pop_front()));
            end
        end
        last_ack_a = ea;
        last_ack_b = eb;
        next_cycle();
    endtask

    initial begin
        logic [1:0] seq[8];
        logic [1:0] exp_seq[8];
        logic [15:0] held;
        int n;

        // Forced-Left_Sig vectors; pri and FSM state evolve through the table.
        tbl[0]  = '{1, 1, 3'd4, 1, 0, 0, 16'h1111};
        tbl[1]  = '{1, 1, 3'd2, 0, 1, 1, 16'h2222};
        tbl[2]  = '{1, 1, 3'd0, 0, 0, 0, 16'h0000};
        tbl[3]  = '{0, 1, 3'd3, 0, 1, 1, 16'h2222};
        tbl[4]  = '{1, 1, 3'd1, 1, 0, 0, 16'h1111};
        tbl[5]  = '{1, 0, 3'd4, 1, 0, 0, 16'h1111};
        tbl[6]  = '{1, 1, 3'd2, 0, 1, 1, 16'h2222};
        tbl[7]  = '{0, 0, 3'd2, 0, 0, 0, 16'h0000};
        tbl[8]  = '{1, 1, 3'd4, 1, 0, 0, 16'h1111};
        tbl[9]  = '{0, 1, 3'd1, 0, 1, 1, 16'h2222};
        tbl[10] = '{1, 1, 3'd3, 1, 0, 0, 16'h1111};

        // ---- table phase ----
        tbl_mode  = 1'b1;
        Out_Ready = 1'b1;
        A_Data    = 16'h1111;
        B_Data    = 16'h2222;
        do_reset();
        for (int i = 0; i < 11; i++) begin
            A_Req    = tbl[i].a;
            B_Req    = tbl[i].b;
            tbl_left = tbl[i].left;
            @(negedge CLK);
            chk($sformatf("tbl[%0d]", i),
                32'({A_Ack, B_Ack, Write_Req, Read_Req, FIFO_Write_Data}),
                32'({tbl[i].ack_a, tbl[i].ack_b, tbl[i].ack_a | tbl[i].ack_b, tbl[i].rd,
                     tbl[i].wdata}));
            next_cycle();
        end
        A_Req    = 1'b0;
        B_Req    = 1'b0;
        tbl_mode = 1'b0;

        // ---- single write then read ----
        do_reset();
        Out_Ready = 1'b1;
        A_Req  = 1'b1;
        A_Data = 16'h1234;
        @(negedge CLK);
        chk("sw_ack", 32'({A_Ack, Write_Req, Read_Req, FIFO_Write_Data}),
            32'({1'b1, 1'b1, 1'b0, 16'h1234}));
        next_cycle();
        A_Req = 1'b0;
        @(negedge CLK);
        chk("sw_readreq", 32'({A_Ack, Read_Req}), 32'({1'b0, 1'b1}));
        next_cycle();
        @(negedge CLK);
        chk("sw_wait", 32'({Read_Req, Out_Valid}), 32'd0);
        next_cycle();
        @(negedge CLK);
        chk("sw_out", 32'({Out_Valid, Out_Data}), 32'({1'b1, 16'h1234}));
        next_cycle();
        @(negedge CLK);
        chk("sw_idle", 32'({Out_Valid, Read_Req}), 32'd0);
        next_cycle();

        // ---- contention from reset (also reset-state checks) ----
        A_Req     = 1'b1;
        B_Req     = 1'b1;
        A_Data    = 16'hAAAA;
        B_Data    = 16'hBBBB;
        Out_Ready = 1'b0;
        RSTn      = 1'b0;
        @(negedge CLK);
        chk("rst_no_ack", 32'({A_Ack, B_Ack, Write_Req}), 32'd0);
        chk("rst_state", 32'({Out_Valid, Out_Data, Read_Req}), 32'd0);
        next_cycle();
        RSTn = 1'b1;
        exp_seq[0] = 2'b01; exp_seq[1] = 2'b10; exp_seq[2] = 2'b01; exp_seq[3] = 2'b10;
        exp_seq[4] = 2'b01; exp_seq[5] = 2'b00; exp_seq[6] = 2'b00; exp_seq[7] = 2'b00;
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            seq[i] = {B_Ack, A_Ack};
            next_cycle();
        end
        for (int i = 0; i < 8; i++) chk($sformatf("cont_ack[%0d]", i), 32'(seq[i]), 32'(exp_seq[i]));
        @(negedge CLK);
        chk("cont_full", 32'({Left_Sig, Write_Req}), 32'({3'd0, 1'b0}));
        chk("cont_hold", 32'({Out_Valid, Out_Data}), 32'({1'b1, 16'hAAAA}));
        next_cycle();

        // ---- full: A stalls until a read frees a slot ----
        B_Req  = 1'b0;
        A_Data = 16'h5555;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk($sformatf("full_stall[%0d]", i), 32'({A_Ack, Write_Req}), 32'd0);
            next_cycle();
        end
        Out_Ready = 1'b1;
        @(negedge CLK);
        chk("full_read", 32'({Read_Req, A_Ack}), 32'({1'b1, 1'b0}));
        next_cycle();
        Out_Ready = 1'b0;
        @(negedge CLK);
        chk("full_land", 32'({A_Ack, Write_Req, FIFO_Write_Data}), 32'({1'b1, 1'b1, 16'h5555}));
        next_cycle();
        A_Req = 1'b0;

        // ---- backpressure: Out_Data stable, no reads for 10 cycles ----
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            chk($sformatf("bp[%0d]", i), 32'({Out_Valid, Read_Req, Out_Data}),
                32'({1'b1, 1'b0, 16'hBBBB}));
            next_cycle();
        end
        Out_Ready = 1'b1;
        @(negedge CLK);
        chk("bp_release_read", 32'(Read_Req), 32'd1);
        next_cycle();

        // ---- randomized run with scoreboard ----
        A_Req     = 1'b0;
        B_Req     = 1'b0;
        Out_Ready = 1'b0;
        do_reset();
        sb.delete();
        pri_m      = 1'b0;
        last_ack_a = 1'b0;
        last_ack_b = 1'b0;
        rd_hist    = 2'b00;
        was_stall  = 1'b0;
        stall_data = '0;
        for (int i = 0; i < 200; i++) rand_step(1'b1);
        n = 0;
        while ((sb.size() != 0 || Out_Valid) && n < 60) begin
            rand_step(1'b0);
            n++;
        end
        chk("rnd_drained", 32'(sb.size()), 32'd0);

        // ---- reset while in WAIT ----
        A_Req     = 1'b0;
        B_Req     = 1'b0;
        Out_Ready = 1'b1;
        do_reset();
        A_Req  = 1'b1;
        A_Data = 16'h7777;
        next_cycle();
        A_Req = 1'b0;
        @(negedge CLK);
        chk("rw_readreq", 32'(Read_Req), 32'd1);
        next_cycle();
        RSTn = 1'b0;
        #1;
        chk("rw_reset_now", 32'({Out_Valid, Read_Req, Out_Data}), 32'd0);
        next_cycle();
        RSTn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            chk($sformatf("rw_no_stale[%0d]", i), 32'({Out_Valid, Read_Req}), 32'd0);
            next_cycle();
        end
        A_Req  = 1'b1;
        A_Data = 16'h8888;
        next_cycle();
        A_Req = 1'b0;
        @(negedge CLK);
        chk("rw_idle_read", 32'(Read_Req), 32'd1);
        next_cycle();
        next_cycle();
        @(negedge CLK);
        chk("rw_new_word", 32'({Out_Valid, Out_Data}), 32'({1'b1, 16'h8888}));
        held = Out_Data;
        next_cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation still running, expected completion");
        $fatal(1, "timeout");
    end

endmodule
